minterm_sweep_checker: RTL and testbench

Sequential stimulus and capture stage that sits directly upstream of a pair of N-input combinational function blocks, e.g. a canonical SoP and its minimized form.
- Drives every input vector 0..2^N-1 onto the blocks' shared inputs.
- Samples both outputs after a programmable settle time and builds both truth tables.
- Counts mismatches and reports equivalence.
- Replaces the loop-and-display bench style with a synthesizable in-design checker.

---
 rtl/minterm_sweep_checker.sv | 108 ++++++++++
 tb/tb_minterm_sweep_checker.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/minterm_sweep_checker.sv
// Sweeps every N-bit input vector into two combinational function blocks, captures both
// truth tables and reports mismatches. Define SWEEP_GRAY_EN for reflected-Gray sweep order.
module minterm_sweep_checker #(
  parameter int N      = 4,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              fa,
  input  logic              fb,
  output logic [N-1:0]      vec,
  output logic              busy,
  output logic              done,
  output logic              equal,
  output logic [(1<<N)-1:0] tt_a,
  output logic [(1<<N)-1:0] tt_b,
  output logic [N:0]        mismatch_cnt,
  output logic [N-1:0]      first_mismatch
);

  localparam logic [1:0]   S_IDLE   = 2'd0;
  localparam logic [1:0]   S_DRIVE  = 2'd1;
  localparam logic [1:0]   S_DONE   = 2'd2;
  localparam logic [3:0]   SETTLE_C = 4'(SETTLE);
  localparam logic [N-1:0] LAST     = '1;

  logic [1:0]   state;
  logic [N-1:0] step;      // sweep position k; vec is derived from it
  logic [3:0]   cnt;
  logic [N-1:0] next_step;
  logic [N-1:0] next_vec;
  logic         mism;
  logic [N:0]   next_mm;

  always_comb begin
    next_step = step + 1'b1;
`ifdef SWEEP_GRAY_EN
    next_vec  = next_step ^ (next_step >> 1);
`else
    next_vec  = next_step;
`endif
    mism      = fa ^ fb;
    // Cannot wrap: at most 2^N increments into an N+1 bit counter.
    next_mm   = mismatch_cnt + {{N{1'b0}}, mism};
  end

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values; the truth-table bits are flops with a reset, not a RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      step           <= '0;
      cnt            <= '0;
      vec            <= '0;
      tt_a           <= '0;
      tt_b           <= '0;
      mismatch_cnt   <= '0;
      first_mismatch <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      equal          <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state          <= S_DRIVE;
            step           <= '0;
            cnt            <= '0;
            vec            <= '0;
            tt_a           <= '0;
            tt_b           <= '0;
            mismatch_cnt   <= '0;
            first_mismatch <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            equal          <= 1'b0;
          end
        end
        S_DRIVE: begin
          if (cnt != SETTLE_C) begin
            cnt <= cnt + 4'd1;
          end else begin
            tt_a[vec] <= fa;
            tt_b[vec] <= fb;
            cnt       <= '0;
            if (mism) begin
              mismatch_cnt <= next_mm;
              // Earliest in sweep order; equals lowest index in the binary build.
              if (mismatch_cnt == '0) first_mismatch <= vec;
            end
            if (step == LAST) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              equal <= (next_mm == '0);
            end else begin
              step <= next_step;
              vec  <= next_vec;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_minterm_sweep_checker.sv
// Scoreboard bench for minterm_sweep_checker: stimulus pushes expected sweep results,
// per-instance monitors pop and compare when done rises.
module tb_minterm_sweep_checker;

  typedef struct {
    string       name;
    logic [15:0] ta;
    logic [15:0] tb;
    logic [4:0]  mm;
    logic [3:0]  fm;
    logic        eq;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start0;
  logic [3:0]  vec, vec0;
  logic        fa, fb, fa0, fb0;
  logic        busy, done, equal, busy0, done0, equal0;
  logic [15:0] tt_a, tt_b, tt_a0, tt_b0;
  logic [4:0]  mismatch_cnt, mismatch_cnt0;
  logic [3:0]  first_mismatch, first_mismatch0;
  int          mode;
  int          errors = 0;
  int          checks = 0;
  exp_t        sb[$];
  exp_t        sb0[$];

  always #5 clk = ~clk;

  // Canonical SoP(2,8,13,14); v[3]=x, v[2]=y, v[1]=z, v[0]=w.
  function automatic logic sop_canon(input logic [3:0] v);
    return (~v[3] & ~v[2] &  v[1] & ~v[0]) | ( v[3] & ~v[2] & ~v[1] & ~v[0]) |
           ( v[3] &  v[2] & ~v[1] &  v[0]) | ( v[3] &  v[2] &  v[1] & ~v[0]);
  endfunction

  function automatic logic sop_min(input logic [3:0] v);
    return (~v[2] & ~v[0] & (v[3] ^ v[1])) | (v[3] & v[2] & (v[1] ^ v[0]));
  endfunction

  function automatic logic fb_sel(input int m, input logic [3:0] v);
    case (m)
      1:       return 1'b0;
      2:       return (v == 4'd2 || v == 4'd3) ? 1'b1 : sop_canon(v);
      default: return sop_min(v);
    endcase
  endfunction

  function automatic logic [3:0] exp_vec(input int k);
    logic [3:0] kk;
    kk = 4'(k);
`ifdef SWEEP_GRAY_EN
    return kk ^ (kk >> 1);
`else
    return kk;
`endif
  endfunction

  function automatic exp_t mk(input string n, input logic [15:0] ta, input logic [15:0] tb,
                              input logic [4:0] mm, input logic [3:0] fm, input logic eq,
                              input int lat);
    exp_t e;
    e.name = n; e.ta = ta; e.tb = tb; e.mm = mm; e.fm = fm; e.eq = eq; e.lat = lat;
    return e;
  endfunction

  assign fa  = sop_canon(vec);
  assign fb  = fb_sel(mode, vec);
  assign fa0 = sop_canon(vec0);
  assign fb0 = sop_min(vec0);

  minterm_sweep_checker #(.N(4), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fa(fa), .fb(fb), .vec(vec),
    .busy(busy), .done(done), .equal(equal), .tt_a(tt_a), .tt_b(tt_b),
    .mismatch_cnt(mismatch_cnt), .first_mismatch(first_mismatch)
  );

  minterm_sweep_checker #(.N(4), .SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .fa(fa0), .fb(fb0), .vec(vec0),
    .busy(busy0), .done(done0), .equal(equal0), .tt_a(tt_a0), .tt_b(tt_b0),
    .mismatch_cnt(mismatch_cnt0), .first_mismatch(first_mismatch0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_result(input exp_t e, input logic [15:0] ta, input logic [15:0] tb,
                                input logic [4:0] mm, input logic [3:0] fm, input logic eq,
                                input int lat);
    check({e.name, ".tt_a"},           32'(ta),  32'(e.ta));
    check({e.name, ".tt_b"},           32'(tb),  32'(e.tb));
    check({e.name, ".mismatch_cnt"},   32'(mm),  32'(e.mm));
    check({e.name, ".first_mismatch"}, 32'(fm),  32'(e.fm));
    check({e.name, ".equal"},          32'(eq),  32'(e.eq));
    check({e.name, ".latency"},        32'(lat), 32'(e.lat));
  endtask

  task automatic unexpected_done(input string who);
    checks++;
    errors++;
    $display("FAIL %s: done rose with no expected result queued", who);
  endtask

  // Monitor for the SETTLE=1 instance
  initial begin
    int   cyc = 0;
    int   st = 0;
    logic bp = 1'b0;
    logic dp = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (busy && !bp) st = cyc;
      if (done && !dp) begin
        if (sb.size() == 0) unexpected_done("dut");
        else compare_result(sb.pop_front(), tt_a, tt_b, mismatch_cnt, first_mismatch,
                            equal, cyc - st);
      end
      bp = busy;
      dp = done;
    end
  end

  // Monitor for the SETTLE=0 instance
  initial begin
    int   cyc = 0;
    int   st = 0;
    logic bp = 1'b0;
    logic dp = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (busy0 && !bp) st = cyc;
      if (done0 && !dp) begin
        if (sb0.size() == 0) unexpected_done("dut0");
        else compare_result(sb0.pop_front(), tt_a0, tt_b0, mismatch_cnt0, first_mismatch0,
                            equal0, cyc - st);
      end
      bp = busy0;
      dp = done0;
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    logic prev;
    prev = done;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (done && !prev) return;
      prev = done;
    end
    check("wait_done_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".vec"},            32'(vec),            32'd0);
    check({tag, ".busy"},           32'(busy),           32'd0);
    check({tag, ".done"},           32'(done),           32'd0);
    check({tag, ".equal"},          32'(equal),          32'd0);
    check({tag, ".tt_a"},           32'(tt_a),           32'd0);
    check({tag, ".tt_b"},           32'(tt_b),           32'd0);
    check({tag, ".mismatch_cnt"},   32'(mismatch_cnt),   32'd0);
    check({tag, ".first_mismatch"}, 32'(first_mismatch), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   seen;
    logic prev;
    rst_n  = 1'b0;
    start  = 1'b0;
    start0 = 1'b0;
    mode   = 0;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    check("reset.busy0", 32'(busy0), 32'd0);
    rst_n = 1'b1;

    // 1: canonical vs minimized form
    sb.push_back(mk("equiv", 16'h6104, 16'h6104, 5'd0, 4'd0, 1'b1, 32));
    pulse_start();
    wait_done(40);
    repeat (3) @(negedge clk);
    check("done_hold.done", 32'(done), 32'd1);
    check("done_hold.tt_a", 32'(tt_a), 32'h6104);
    check("done_hold.busy", 32'(busy), 32'd0);

    // 2: fb tied low
    mode = 1;
    sb.push_back(mk("fb_zero", 16'h6104, 16'h0000, 5'd4, 4'd2, 1'b0, 32));
    pulse_start();
    wait_done(40);

    // 3: SETTLE=0, vec must advance every cycle
    sb0.push_back(mk("settle0", 16'h6104, 16'h6104, 5'd0, 4'd0, 1'b1, 16));
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("settle0.vec[%0d]", k), 32'(vec0), 32'(exp_vec(k)));
      @(negedge clk);
    end
    repeat (2) @(negedge clk);

    // Back-to-back sweeps with start held high on the SETTLE=0 instance
    sb0.push_back(mk("b2b_1", 16'h6104, 16'h6104, 5'd0, 4'd0, 1'b1, 16));
    sb0.push_back(mk("b2b_2", 16'h6104, 16'h6104, 5'd0, 4'd0, 1'b1, 16));
    start0 = 1'b1;
    seen = 0;
    prev = done0;
    for (int n = 0; n < 60 && seen < 2; n++) begin
      @(negedge clk);
      if (done0 && !prev) seen++;
      prev = done0;
    end
    start0 = 1'b0;
    check("b2b.done_count", 32'(seen), 32'd2);
    repeat (3) @(negedge clk);

    // 4: async reset mid-sweep
    mode = 0;
    sb.push_back(mk("aborted", 16'h6104, 16'h6104, 5'd0, 4'd0, 1'b1, 32));
    pulse_start();
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("midreset");
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    sb.push_back(mk("after_reset", 16'h6104, 16'h6104, 5'd0, 4'd0, 1'b1, 32));
    pulse_start();
    wait_done(40);

    // 5: start pulsed while busy must be ignored
    sb.push_back(mk("start_busy", 16'h6104, 16'h6104, 5'd0, 4'd0, 1'b1, 32));
    pulse_start();
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(40);
    repeat (2) @(negedge clk);
    check("start_busy.idle_after", 32'(busy), 32'd0);

    // 6: fb forced high at minterms 2 and 3; checks sweep order too
    mode = 2;
    sb.push_back(mk("force23", 16'h6104, 16'h610C, 5'd1, 4'd3, 1'b0, 32));
    pulse_start();
    for (int k = 0; k < 16; k++) begin
      check($sformatf("force23.vec[%0d]", k), 32'(vec), 32'(exp_vec(k)));
      repeat (2) @(negedge clk);
    end
    repeat (2) @(negedge clk);

    check("pending_dut",  32'(sb.size()),  32'd0);
    check("pending_dut0", 32'(sb0.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
